// File: rtl/sd_block_writer.sv
// rtl/sd_block_writer.sv - collects a byte stream into 512-byte blocks and writes them through the SD controller
// Bytes fill a 512x8 buffer; the full block is then streamed one byte per ready_for_next_byte rising edge.
module sd_block_writer #(
  parameter logic [31:0] START_ADR = 32'h0010_0000,
  parameter logic [31:0] STOP_ADR  = 32'h0014_0000,
  parameter logic [7:0]  PAD_BYTE  = 8'h80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sd_ready,
  input  logic        sd_ready_for_next_byte,
  output logic        sd_wr,
  output logic [7:0]  sd_din,
  output logic [31:0] sd_adr,
  output logic        busy,
  output logic        done,
  output logic [15:0] blocks_written,
  output logic        overflow
);

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_PAD, S_WAIT_READY, S_ISSUE, S_STREAM, S_WAIT_DONE, S_NEXT, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_mem [0:511];
  logic [9:0]  r_cnt;
  logic [8:0]  r_idx;
  logic [7:0]  r_dout;
  logic [31:0] r_adr;
  logic [15:0] r_blocks;
  logic        r_ovf;
  logic        r_flushed;
  logic        r_rfnb_prev;

  logic        w_accept;
  logic [9:0]  w_cnt_acc;
  logic        w_edge;
  logic [8:0]  w_idx_nxt;
  logic [31:0] w_adr_inc;
  logic        w_we;
  logic [7:0]  w_wdata;
  logic        w_rd_en;

  assign w_accept  = in_ready && in_valid;
  assign w_cnt_acc = r_cnt + {9'd0, w_accept};
  assign w_edge    = (r_state == S_STREAM) && sd_ready_for_next_byte && !r_rfnb_prev;
  assign w_idx_nxt = r_idx + {8'd0, w_edge};
  assign w_adr_inc = r_adr + 32'h0000_0200;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    sd_wr       = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    w_we        = 1'b0;
    w_wdata     = in_data;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        in_ready = (r_cnt < 10'd512);
        w_we     = w_accept;
        // the byte arriving with flush is stored before padding starts
        if (flush) begin
          if (w_cnt_acc == 10'd0)        w_state_nxt = S_DONE;
          else if (w_cnt_acc == 10'd512) w_state_nxt = S_WAIT_READY;
          else                           w_state_nxt = S_PAD;
        end else if (w_cnt_acc == 10'd512) begin
          w_state_nxt = S_WAIT_READY;
        end
      end
      S_PAD: begin
        w_we    = 1'b1;
        w_wdata = PAD_BYTE;
        if (r_cnt == 10'd511) w_state_nxt = S_WAIT_READY;
      end
      S_WAIT_READY: begin
        w_rd_en = 1'b1;
        if (sd_ready) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_rd_en = 1'b1;
        sd_wr   = 1'b1;
        if (!sd_ready) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_rd_en = 1'b1;
        if (w_edge && r_idx == 9'd511) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (sd_ready) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (r_flushed || w_adr_inc >= STOP_ADR) w_state_nxt = S_DONE;
        else                                    w_state_nxt = S_FILL;
      end
      S_DONE: begin
        busy        = 1'b0;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we && !reset) r_mem[r_cnt[8:0]] <= w_wdata;
  end

  // read address looks one edge ahead so the next byte is ready within a cycle of each request
  always_ff @(posedge clk) begin
    if (reset)        r_dout <= 8'h00;
    else if (w_rd_en) r_dout <= r_mem[w_idx_nxt];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 10'd0;
      r_idx       <= 9'd0;
      r_adr       <= 32'd0;
      r_blocks    <= 16'd0;
      r_ovf       <= 1'b0;
      r_flushed   <= 1'b0;
      r_rfnb_prev <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rfnb_prev <= sd_ready_for_next_byte;
      if (busy && in_valid && !in_ready) r_ovf <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_adr     <= START_ADR;
            r_blocks  <= 16'd0;
            r_ovf     <= 1'b0;
            r_flushed <= 1'b0;
            r_cnt     <= 10'd0;
            r_idx     <= 9'd0;
          end
        end
        S_FILL: begin
          r_cnt <= w_cnt_acc;
          if (flush && w_cnt_acc != 10'd0) r_flushed <= 1'b1;
        end
        S_PAD:    r_cnt <= r_cnt + 10'd1;
        S_STREAM: r_idx <= w_idx_nxt;
        S_NEXT: begin
          r_blocks <= r_blocks + 16'd1;
          r_adr    <= w_adr_inc;
          r_cnt    <= 10'd0;
        end
        default: ;
      endcase
    end
  end

  assign sd_din         = r_dout;
  assign sd_adr         = r_adr;
  assign blocks_written = r_blocks;
  assign overflow       = r_ovf;

endmodule

// File: tb/tb_sd_block_writer.sv
// tb/tb_sd_block_writer.sv - randomized self-checking bench for sd_block_writer with a behavioural model
module tb_sd_block_writer;
  localparam logic [31:0] START = 32'h0010_0000;
  localparam logic [31:0] STOP  = 32'h0010_0400;
  localparam logic [7:0]  PAD   = 8'h80;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        sd_ready = 1'b1;
  logic        rfnb = 1'b0;
  logic        in_ready, sd_wr, busy, done, overflow;
  logic [7:0]  sd_din;
  logic [31:0] sd_adr;
  logic [15:0] blocks_written;

  sd_block_writer #(.START_ADR(START), .STOP_ADR(STOP), .PAD_BYTE(PAD)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sd_ready(sd_ready), .sd_ready_for_next_byte(rfnb),
    .sd_wr(sd_wr), .sd_din(sd_din), .sd_adr(sd_adr),
    .busy(busy), .done(done), .blocks_written(blocks_written), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model state
  bit          mon_en = 0;
  bit          m_busy = 0, m_collecting = 0, m_pending = 0, m_wait_ack = 0, m_next = 0;
  bit          m_flushed = 0, m_done = 0, m_ovf = 0, m_rfnb_prev = 0;
  int          m_cnt = 0, m_edges = 0;
  logic [31:0] m_adr = 0;
  logic [15:0] m_blocks = 0;
  logic [7:0]  exp_q [$];
  int          xfer_cnt = 0;
  int          n_done = 0;

  // stimulus controls
  bit          src_on = 0, src_gaps = 0;
  int          src_limit = 0;
  logic [7:0]  src_key = 8'h00;
  int          sd_hold_fixed = 0;
  int          sd_abort_at = 0;
  bit          sd_aborted = 0;
  int          wr_seen = 0;
  logic [31:0] adr_log [0:7];
  logic [7:0]  got [0:511];

  // samples one time unit before each rising edge: outputs of this cycle, inputs of this edge
  always begin
    bit done_n;
    @(negedge clk);
    #4;
    if (mon_en) begin
      chk("in_ready", in_ready, m_collecting);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("blocks_written", blocks_written, m_blocks);
      chk("sd_adr", sd_adr, m_adr);
      chk("overflow", overflow, m_ovf);
      if (!(m_pending && m_edges == 0)) chk("sd_wr_unexpected", sd_wr, 0);
      if (done) n_done++;

      if (reset) begin
        m_busy = 0; m_collecting = 0; m_pending = 0; m_wait_ack = 0; m_next = 0;
        m_flushed = 0; m_done = 0; m_ovf = 0; m_cnt = 0; m_edges = 0;
        m_adr = 0; m_blocks = 0;
        exp_q.delete();
      end else begin
        done_n = 0;
        if (m_busy && in_valid && !m_collecting) m_ovf = 1;
        if (!m_busy && !m_done) begin
          if (start) begin
            m_busy = 1; m_collecting = 1; m_cnt = 0; m_edges = 0;
            m_adr = START; m_blocks = 0; m_ovf = 0; m_flushed = 0;
          end
        end else if (m_collecting) begin
          if (in_valid) begin
            exp_q.push_back(in_data);
            m_cnt++;
            xfer_cnt++;
          end
          if (flush) begin
            if (m_cnt == 0) begin
              m_collecting = 0; m_busy = 0; done_n = 1;
            end else begin
              while (m_cnt < 512) begin
                exp_q.push_back(PAD);
                m_cnt++;
              end
              m_collecting = 0; m_pending = 1; m_flushed = 1;
            end
          end else if (m_cnt == 512) begin
            m_collecting = 0; m_pending = 1;
          end
        end else if (m_pending) begin
          if (rfnb && !m_rfnb_prev) begin
            m_edges++;
            if (m_edges == 512) begin
              m_edges = 0; m_pending = 0; m_wait_ack = 1;
            end
          end
        end else if (m_wait_ack) begin
          if (sd_ready) begin
            m_wait_ack = 0; m_next = 1;
          end
        end else if (m_next) begin
          m_next = 0;
          m_blocks = m_blocks + 16'd1;
          m_adr = m_adr + 32'h200;
          m_cnt = 0;
          if (m_flushed || m_adr >= STOP) begin
            m_busy = 0; done_n = 1;
          end else begin
            m_collecting = 1;
          end
        end
        m_done = done_n;
      end
      m_rfnb_prev = reset ? 1'b0 : rfnb;
    end
  end

  // byte source: the data value is tied to the index of the accepted byte
  always @(negedge clk) begin
    if (src_on && xfer_cnt < src_limit) begin
      in_valid = src_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = 8'(xfer_cnt) ^ src_key;
    end else begin
      in_valid = 1'b0;
    end
  end

  // SD controller stand-in: accepts the command, then requests and checks 512 bytes
  initial begin
    int hold;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (sd_wr) begin
        adr_log[wr_seen % 8] = sd_adr;
        wr_seen++;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        sd_ready = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        for (int i = 0; i < 512; i++) begin
          if (exp_q.size() == 0) begin
            chk("sd_din_no_expected_byte", exp_q.size(), 1);
            e = 8'hxx;
          end else begin
            e = exp_q.pop_front();
            chk("sd_din", sd_din, e);
          end
          got[i] = sd_din;
          rfnb = 1'b1;
          hold = (sd_hold_fixed != 0) ? sd_hold_fixed : $urandom_range(1, 3);
          repeat (hold) @(negedge clk);
          rfnb = 1'b0;
          repeat ($urandom_range(1, 2)) @(negedge clk);
          if (sd_abort_at != 0 && i + 1 == sd_abort_at) begin
            sd_aborted = 1;
            break;
          end
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        sd_ready = 1'b1;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    mon_en = 1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_sd_adr", sd_adr, 0);

    // two full blocks of 0x00..0xFF, second one with 4-cycle requests; STOP ends the session
    xfer_cnt = 0; src_key = 8'h00; src_gaps = 0; src_limit = 1000000; src_on = 1;
    pulse_start();
    for (int c = 0; c < 8000 && blocks_written != 16'd1; c++) @(negedge clk);
    chk("t1_blocks_written", blocks_written, 16'd1);
    chk("t1_sd_adr_next", sd_adr, 32'h0010_0200);
    chk("t1_back_in_fill", in_ready, 1);
    chk("t1_wr_adr", adr_log[0], 32'h0010_0000);
    chk("t1_byte300", got[300], 8'h2C);
    chk("t1_byte511", got[511], 8'hFF);
    sd_hold_fixed = 4;
    for (int c = 0; c < 10000 && n_done == 0; c++) @(negedge clk);
    chk("t4_done_count", n_done, 1);
    repeat (3) @(negedge clk);
    chk("t4_blocks", blocks_written, 16'd2);
    chk("t4_wr_count", wr_seen, 2);
    chk("t2_wr_adr", adr_log[1], 32'h0010_0200);
    chk("t2_byte0", got[0], 8'h00);
    chk("t2_byte255", got[255], 8'hFF);
    chk("t2_queue_empty", exp_q.size(), 0);
    chk("t4_in_valid_held", in_valid, 1);
    chk("t4_in_ready_idle", in_ready, 0);
    chk("t5_overflow_sticky", overflow, 1);
    src_on = 0; sd_hold_fixed = 0;

    // 100 bytes with gaps, then flush: block padded with silence
    @(negedge clk);
    xfer_cnt = 0; src_key = 8'($urandom); src_gaps = 1; src_limit = 100; src_on = 1;
    base = n_done;
    pulse_start();
    chk("t5_overflow_cleared", overflow, 0);
    for (int c = 0; c < 2000 && xfer_cnt < 100; c++) @(negedge clk);
    chk("t3_bytes_in", xfer_cnt, 100);
    pulse_flush();
    for (int c = 0; c < 8000 && n_done == base; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t3_done_once", n_done - base, 1);
    chk("t3_blocks", blocks_written, 16'd1);
    chk("t3_busy", busy, 0);
    chk("t3_overflow", overflow, 0);
    chk("t3_wr_adr", adr_log[(wr_seen - 1) % 8], 32'h0010_0000);
    chk("t3_last_data", got[99], 8'(99) ^ src_key);
    chk("t3_first_pad", got[100], 8'h80);
    chk("t3_last_pad", got[511], 8'h80);
    src_on = 0;

    // reset in the middle of streaming, then a fresh session starts at START again
    @(negedge clk);
    xfer_cnt = 0; src_key = 8'($urandom); src_gaps = 0; src_limit = 512; src_on = 1;
    sd_aborted = 0; sd_abort_at = 200;
    pulse_start();
    for (int c = 0; c < 6000 && !sd_aborted; c++) @(negedge clk);
    chk("t6_reached_byte200", sd_aborted, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_sd_wr", sd_wr, 0);
    chk("t6_rst_sd_din", sd_din, 0);
    chk("t6_rst_sd_adr", sd_adr, 0);
    chk("t6_rst_blocks", blocks_written, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    reset = 1'b0; sd_abort_at = 0; src_on = 0;
    @(negedge clk);
    xfer_cnt = 0; src_on = 1;
    base = n_done;
    pulse_start();
    for (int c = 0; c < 8000 && blocks_written != 16'd1; c++) @(negedge clk);
    chk("t6_blocks", blocks_written, 16'd1);
    chk("t6_wr_adr", adr_log[(wr_seen - 1) % 8], 32'h0010_0000);
    src_on = 0;
    @(negedge clk);
    pulse_flush();
    for (int c = 0; c < 50 && n_done == base; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("t6_empty_flush_done", n_done - base, 1);
    chk("t6_empty_flush_blocks", blocks_written, 16'd1);
    chk("t6_busy_end", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
